inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch unit: the producer side of the IF/ID interface that feeds the decoder.
- Owns the PC and assembles each 32-bit instruction from a byte-wide synchronous RAM read port.
- Presents (pc_o, inst_o, inst_valid_o) to the IF/ID register and raises a stall request while a word is incomplete.
- Redirected by EX on taken branch/jump; shares the RAM port with MEM via mem_busy_i.

Parameters:
ADDR_W, 32, PC and memory address width
INST_W, 32, instruction width
INST_BYTES, 4, bytes per instruction (INST_W/8)
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-low (ResetEnable = 1'b0)
rdy_i  input  1  chip ready; when 0 all state frozen, outputs held
stall_i  input  1  from stall_ctrl: IF/ID cannot accept; hold current instruction
jump_i  input  1  from EX: redirect fetch
jump_addr_i  input  ADDR_W  redirect target
mem_busy_i  input  1  MEM stage owns RAM port this cycle; no read may issue
mem_din_i  input  8  RAM read data, valid 1 cycle after a granted read
mem_rd_o  output  1  read request (combinational from state)
mem_addr_o  output  ADDR_W  read byte address
pc_o  output  ADDR_W  PC of inst_o (to IF/ID)
inst_o  output  INST_W  assembled instruction, little-endian
inst_valid_o  output  1  pc_o/inst_o valid
stall_if_o  output  1  to stall_ctrl: fetch incomplete

Behaviour:
- Reset (rst==0 at clk edge): pc<=RESET_PC, state<=S_ISSUE, issue_idx<=0, recv_idx<=0, pend<=0, inst buffer<=0.
- While rst==0: every output is 0.
- States:
  - S_ISSUE: drive mem_rd_o=1, mem_addr_o=pc+issue_idx when issue_idx<4 and mem_busy_i==0. A read that issues sets pend<=1 and increments issue_idx; otherwise pend<=0.
  - Capture: when pend==1, mem_din_i is written into byte lane recv_idx (bits 8*recv_idx+7:8*recv_idx) and recv_idx increments.
  - When recv_idx reaches 4 → S_DONE.
  - S_DONE: inst_valid_o=1, pc_o=pc, inst_o=buffer, mem_rd_o=0.
    - stall_i==0: pc<=pc+4, issue_idx<=0, recv_idx<=0, go to S_ISSUE.
    - stall_i==1: hold all state.
- Latency: unstalled with no busy cycles, reads issue on cycles 0-3, bytes are captured on cycles 1-4, inst_valid_o is high on cycle 5, and the next fetch issues on cycle 6 (6 cycles per instruction).
- mem_busy_i mid-word: issue pauses. A byte already in flight (pend==1) is still captured. Ordering is preserved because the address is computed from issue_idx.
- stall_if_o = 1 in S_ISSUE and 0 in S_DONE.
- Jump priority: jump_i==1 overrides stall_i and all other activity.
  - Next state: pc<=jump_addr_i, S_ISSUE, issue_idx=recv_idx=0, pend<=0.
  - Any byte arriving the following cycle is discarded.
  - inst_valid_o is 0 on the cycle after the jump.
- Same-cycle jump_i with the last byte capture: the byte is dropped and no instruction is presented.
- rdy_i==0: no state changes and no issue (mem_rd_o=0). Outputs other than mem_rd_o hold. rst==0 still overrides rdy_i.
- Address arithmetic is modulo 2^ADDR_W: pc+issue_idx and pc+4 wrap silently. No alignment check is performed; a misaligned jump_addr_i is fetched as given.
- No instruction is ever presented with a partially stale buffer: the buffer lanes are fully rewritten before S_DONE.

Decomposition:
- Shared defines header holds the existing globals ResetEnable, AddrLen, InstLen, ZERO_WORD, plus new state encodings IF_S_ISSUE and IF_S_DONE.
- No sub-module is needed. Byte assembly is an in-module indexed write; a separate byte_assembler would be a thin wrapper.

Test Plan:
- Reset then release, RAM[0..3]=13 05 10 00, no stall/busy → cycle 5: inst_valid_o=1, pc_o=0, inst_o=32'h00100513; addresses 0,1,2,3 seen on cycles 0-3.
- mem_busy_i high on cycles 1-2 of fetch at pc=0 → addresses 0,1,2,3 issued on cycles 0,3,4,5; inst_valid_o on cycle 7 with the correct word; byte issued on cycle 0 still captured.
- stall_i high for 3 cycles while in S_DONE → pc_o/inst_o stable, no mem_rd_o, next fetch at pc=4 begins on the cycle after stall_i falls.
- jump_i=1 with jump_addr_i=32'h100 during the third byte read at pc=8 → next cycle mem_addr_o=32'h100; the in-flight byte from 32'hA is discarded; the presented word comes from 0x100-0x103.
- jump_i and stall_i both high in S_DONE → redirect taken; inst_valid_o=0 the next cycle.
- Synchronous reset (rst=0 for 1 cycle) mid-fetch at pc=32'h40 → all outputs 0 that cycle; fetch restarts at RESET_PC; rdy_i=0 for 2 cycles mid-word freezes issue_idx/recv_idx with mem_rd_o=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared globals and fetch FSM state encodings
// Holds the reset level, the address/instruction widths, the zero word and
// the state type used by inst_fetch.
package inst_fetch_pkg;
    localparam logic ResetEnable = 1'b0;
    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam logic [InstLen-1:0] ZERO_WORD = '0;
    typedef enum logic {
        IF_S_ISSUE = 1'b0,
        IF_S_DONE  = 1'b1
    } if_state_t;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch unit assembling 32-bit words from a byte-wide sync RAM
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   rdy_i             chip ready; 0 freezes all state
//   stall_i           IF/ID cannot accept; hold presented instruction
//   jump_i/jump_addr_i redirect from EX (highest priority)
//   mem_busy_i        MEM owns the RAM port this cycle
//   mem_din_i         RAM byte, valid one cycle after a granted read
//   mem_rd_o/mem_addr_o read request and byte address
//   pc_o/inst_o/inst_valid_o instruction presented to IF/ID
//   stall_if_o        fetch of the current word is incomplete
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int INST_W = InstLen,
    parameter int INST_BYTES = InstLen / 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              mem_busy_i,
    input  logic [7:0]        mem_din_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_if_o
);
    localparam int IDX_W = $clog2(INST_BYTES) + 1;

    if_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [IDX_W-1:0]  r_issue_idx;
    logic [IDX_W-1:0]  r_recv_idx;
    logic              r_pend;
    logic [INST_W-1:0] r_buf;
    logic              w_run;
    logic              w_issue;

    assign w_run   = (rst != ResetEnable);
    assign w_issue = w_run && rdy_i && r_state == IF_S_ISSUE &&
                     r_issue_idx < IDX_W'(INST_BYTES) && !mem_busy_i;

    // The address follows issue_idx, so busy gaps never reorder the bytes.
    assign mem_rd_o     = w_issue;
    assign mem_addr_o   = w_run ? r_pc + ADDR_W'(r_issue_idx) : '0;
    assign pc_o         = w_run ? r_pc : '0;
    assign inst_o       = w_run ? r_buf : '0;
    assign inst_valid_o = w_run && r_state == IF_S_DONE;
    assign stall_if_o   = w_run && r_state == IF_S_ISSUE;

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            r_state     <= IF_S_ISSUE;
            r_pc        <= RESET_PC;
            r_issue_idx <= '0;
            r_recv_idx  <= '0;
            r_pend      <= 1'b0;
            r_buf       <= INST_W'(ZERO_WORD);
        end else if (rdy_i) begin
            if (jump_i) begin
                // Clearing pend drops whatever byte lands next cycle.
                r_state     <= IF_S_ISSUE;
                r_pc        <= jump_addr_i;
                r_issue_idx <= '0;
                r_recv_idx  <= '0;
                r_pend      <= 1'b0;
            end else if (r_state == IF_S_ISSUE) begin
                r_pend <= w_issue;
                if (w_issue)
                    r_issue_idx <= r_issue_idx + IDX_W'(1);
                if (r_pend) begin
                    r_buf[int'(r_recv_idx) * 8 +: 8] <= mem_din_i;
                    r_recv_idx <= r_recv_idx + IDX_W'(1);
                    if (r_recv_idx == IDX_W'(INST_BYTES - 1))
                        r_state <= IF_S_DONE;
                end
            end else if (!stall_i) begin
                r_state     <= IF_S_ISSUE;
                r_pc        <= r_pc + ADDR_W'(INST_BYTES);
                r_issue_idx <= '0;
                r_recv_idx  <= '0;
                r_pend      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch with a byte RAM model and instruction scoreboard
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        mem_busy_i = 1'b0;
    logic [7:0]  mem_din_i = '0;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stall_if_o;

    inst_fetch dut (
        .clk(clk), .rst(rst), .rdy_i(rdy_i), .stall_i(stall_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i), .mem_busy_i(mem_busy_i),
        .mem_din_i(mem_din_i), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .stall_if_o(stall_if_o)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    always @(posedge clk) if (mem_rd_o) mem_din_i <= ram[mem_addr_o[11:0]];

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct { logic [31:0] addr; logic [15:0] bm; logic [15:0] rm; int ev; } vec_t;
    exp_t sb [$];
    vec_t vecs [6];
    int checks = 0;
    int errors = 0;
    logic prev_valid = 1'b0;
    logic rose = 1'b0;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic smp();
        exp_t e;
        #4;
        rose = inst_valid_o && !prev_valid;
        prev_valid = inst_valid_o;
        if (rose) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got valid pc %h, expected no instruction", pc_o);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", pc_o, e.pc);
                chk("sb_inst", inst_o, e.inst);
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Starts at cycle 0 of a fetch at a; returns while sampling its valid cycle.
    task automatic fetch_run(input logic [31:0] a, input logic [15:0] bm,
                             input logic [15:0] rm, input int ev, input string nm);
        int n;
        bit done;
        n = 0;
        done = 0;
        sb.push_back('{a, word(a)});
        for (int c = 0; c < 16 && !done; c++) begin
            mem_busy_i = bm[c];
            rdy_i = !rm[c];
            smp();
            if (c == 0) chk({nm, "_valid_c0"}, 32'(inst_valid_o), 0);
            if (!rdy_i) begin
                chk({nm, "_frozen_rd"}, 32'(mem_rd_o), 0);
                chk({nm, "_frozen_addr"}, mem_addr_o, a + 32'(n));
            end
            if (mem_rd_o) begin
                chk({nm, "_addr"}, mem_addr_o, a + 32'(n));
                n++;
            end
            if (rose) begin
                chk({nm, "_valid_cycle"}, 32'(c), 32'(ev));
                chk({nm, "_issues"}, 32'(n), 4);
                done = 1;
            end else begin
                nxt();
            end
        end
        mem_busy_i = 1'b0;
        rdy_i = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid in 16 cycles, expected valid at cycle %0d", nm, ev);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 37 + 11);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        vecs[0] = '{32'h0000_0080, 16'h0000, 16'h0000, 5};
        vecs[1] = '{32'h0000_0033, 16'h0006, 16'h0000, 7};
        vecs[2] = '{32'h0000_0200, 16'h000F, 16'h0000, 9};
        vecs[3] = '{32'h0000_0124, 16'h000A, 16'h0000, 7};
        vecs[4] = '{32'h0000_0FFC, 16'h0010, 16'h0000, 5};
        vecs[5] = '{32'hFFFF_FFFE, 16'h0001, 16'h0000, 6};

        // Reset: every output low while rst is asserted.
        @(posedge clk);
        #1;
        smp();
        chk("rst_rd", 32'(mem_rd_o), 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_valid", 32'(inst_valid_o), 0);
        chk("rst_stall_if", 32'(stall_if_o), 0);
        nxt();
        rst = 1'b1;

        // First word from reset: addresses 0..3 on cycles 0..3, valid on 5.
        fetch_run(32'h0, 16'h0, 16'h0, 5, "first");
        chk("first_inst", inst_o, 32'h0010_0513);
        chk("first_stall_if", 32'(stall_if_o), 0);

        // Stall while presenting: everything holds, no reads.
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nxt();
            smp();
            chk("stall_valid", 32'(inst_valid_o), 1);
            chk("stall_pc", pc_o, 0);
            chk("stall_inst", inst_o, 32'h0010_0513);
            chk("stall_rd", 32'(mem_rd_o), 0);
        end
        stall_i = 1'b0;
        nxt();
        fetch_run(32'h4, 16'h0, 16'h0, 5, "after_stall");
        nxt();

        // Jump during the third byte read at pc=8.
        smp();
        chk("pc8_addr0", mem_addr_o, 32'h8);
        nxt();
        smp();
        chk("pc8_addr1", mem_addr_o, 32'h9);
        nxt();
        jump_i = 1'b1;
        jump_addr_i = 32'h100;
        smp();
        chk("pc8_addr2", mem_addr_o, 32'hA);
        chk("pc8_rd2", 32'(mem_rd_o), 1);
        nxt();
        jump_i = 1'b0;
        fetch_run(32'h100, 16'h0, 16'h0, 5, "jump");

        // Jump and stall together in the presenting state.
        stall_i = 1'b1;
        jump_i = 1'b1;
        jump_addr_i = 32'h200;
        nxt();
        stall_i = 1'b0;
        jump_i = 1'b0;
        fetch_run(32'h200, 16'h0, 16'h0, 5, "jump_stall");

        // Table: redirect then fetch under a busy/ready pattern.
        for (int v = 0; v < 6; v++) begin
            jump_i = 1'b1;
            jump_addr_i = vecs[v].addr;
            nxt();
            jump_i = 1'b0;
            fetch_run(vecs[v].addr, vecs[v].bm, vecs[v].rm, vecs[v].ev, $sformatf("vec%0d", v));
        end
        // pc + 4 wraps past the top of the address space.
        nxt();
        fetch_run(32'h2, 16'h0, 16'h0, 5, "wrap");

        // Reset in the middle of a fetch at 0x40.
        jump_i = 1'b1;
        jump_addr_i = 32'h40;
        nxt();
        jump_i = 1'b0;
        smp();
        chk("mid_addr0", mem_addr_o, 32'h40);
        nxt();
        smp();
        nxt();
        rst = 1'b0;
        smp();
        chk("midrst_rd", 32'(mem_rd_o), 0);
        chk("midrst_addr", mem_addr_o, 0);
        chk("midrst_pc", pc_o, 0);
        chk("midrst_inst", inst_o, 0);
        chk("midrst_valid", 32'(inst_valid_o), 0);
        chk("midrst_stall_if", 32'(stall_if_o), 0);
        nxt();
        rst = 1'b1;
        fetch_run(32'h0, 16'h0, 16'h0, 5, "restart");
        nxt();

        // rdy low for two cycles mid-word freezes the fetch.
        fetch_run(32'h4, 16'h0, 16'h000C, 7, "rdy");

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
